mmio_uart_tx: RTL and testbench

- Memory-mapped serial transmitter; a bus responder on the `core` CPU bus, alongside `ram`.
- The CPU writes bytes into a small FIFO through register accesses. The block shifts them out on a single 8N1 line: LSB first, idle high.
- A registered read path returns status and divisor values, with a `hit` strobe so the top level can mux it against RAM `D_out`.

---
 rtl/mmio_uart_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter (LSB first, idle high) fed by a small byte FIFO.
// Latency: register reads return on D_out with hit one clock after the access; an idle line starts a frame one clock after a DATA write.
// Backpressure: none on the bus; a DATA write into a full FIFO is dropped and sets the sticky overflow flag.
// Build option: define MMIO_UART_TX_IRQ_EN to add the irq output and the CTRL irq_enable bit.
module mmio_uart_tx #(
    parameter logic [15:0] BASE       = 16'h0400,
    parameter int          DEPTH_LOG2 = 2,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RW,
    input  logic [15:0] AD,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        hit,
    output logic        tx
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic [7:0]            fifo_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [15:0]           div;
    logic [15:0]           bitdiv;
    logic [15:0]           baud_cnt;
    logic [7:0]            shift;
    logic [2:0]            bit_idx;
    logic                  overflow;
    logic [7:0]            rd_val;

`ifdef MMIO_UART_TX_IRQ_EN
    logic                  irq_en;
`endif

    // Window decode: the subtraction wraps, so anything below BASE lands far above 7.
    logic [15:0] offset;
    logic        in_win;
    logic        wr_acc;
    logic        rd_acc;
    assign offset = AD - BASE;
    assign in_win = (offset[15:3] == 13'd0);
    assign wr_acc = in_win & ~RW;
    assign rd_acc = in_win & RW;

    // count never exceeds DEPTH, so its MSB alone marks full.
    logic full;
    logic empty;
    logic busy;
    logic bit_end;
    logic pop;
    logic push;
    logic push_ok;
    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);
    assign busy    = (state != IDLE);
    assign bit_end = (baud_cnt == 16'd0);
    assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
    assign push    = wr_acc & (offset[2:0] == 3'd0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok = push & (~full | pop);

    // Register read mux; reserved offsets and DATA read as zero.
    always_comb begin
        rd_val = 8'h00;
        case (offset[2:0])
            3'd1:    rd_val = {4'b0000, overflow, empty, full, busy};
            3'd2:    rd_val = div[7:0];
            3'd3:    rd_val = div[15:8];
`ifdef MMIO_UART_TX_IRQ_EN
            3'd4:    rd_val = {7'b0000000, irq_en};
`endif
            default: rd_val = 8'h00;
        endcase
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= D_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bus side: registered read data, divisor writes, sticky overflow cleared by a STATUS read.
    always_ff @(posedge clk) begin
        if (rst) begin
            D_out    <= 8'h00;
            hit      <= 1'b0;
            div      <= DIV_RESET;
            overflow <= 1'b0;
        end else begin
            hit <= rd_acc;
            if (rd_acc) begin
                D_out <= rd_val;
            end
            if (push & ~push_ok) begin
                overflow <= 1'b1;
            end else if (rd_acc && (offset[2:0] == 3'd1)) begin
                overflow <= 1'b0;
            end
            if (wr_acc && (offset[2:0] == 3'd2)) begin
                div[7:0] <= D_in;
            end
            if (wr_acc && (offset[2:0] == 3'd3)) begin
                div[15:8] <= D_in;
            end
        end
    end

    // Transmit FSM: each bit lasts bitdiv+1 clocks; the divisor is sampled only at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= 8'h00;
            bitdiv   <= 16'd0;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        shift    <= fifo_mem[rd_ptr];
                        bitdiv   <= div;
                        baud_cnt <= div;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= bitdiv;
                        tx       <= shift[0];
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= bitdiv;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!empty) begin
                            // Back-to-back frame: no idle gap after the stop bit.
                            shift    <= fifo_mem[rd_ptr];
                            bitdiv   <= div;
                            baud_cnt <= div;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MMIO_UART_TX_IRQ_EN
    // Interrupt when enabled and all queued data has fully left the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_acc && (offset[2:0] == 3'd4)) begin
                irq_en <= D_in[0];
            end
            irq <= irq_en & empty & (state == IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized scoreboard bench for mmio_uart_tx: a frame-level reference model predicts
// read responses and serial frames (content and start clock); monitors compare as outputs appear.
module tb_mmio_uart_tx;

    localparam logic [15:0] BASE      = 16'h0400;
    localparam int          DEPTH     = 4;
    localparam int          DIV_RESET = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        RW;
    logic [15:0] AD;
    logic [7:0]  D_in;
    logic [7:0]  D_out;
    logic        hit;
    logic        tx;
`ifdef MMIO_UART_TX_IRQ_EN
    logic        irq;
`endif

    mmio_uart_tx #(
        .BASE      (BASE),
        .DEPTH_LOG2(2),
        .DIV_RESET (16'(DIV_RESET))
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .RW   (RW),
        .AD   (AD),
        .D_in (D_in),
        .D_out(D_out),
        .hit  (hit),
        .tx   (tx)
`ifdef MMIO_UART_TX_IRQ_EN
        ,
        .irq  (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        int         e;
    } rd_t;

    typedef struct {
        logic [7:0] b;
        int         d;
        int         s;
    } fr_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         n = 0;
    logic [7:0] fifo_q[$];
    rd_t        rd_q[$];
    fr_t        ser_q[$];
    int         busy_until = -1;
    logic [15:0] div_m = 16'(DIV_RESET);
    bit         ovf_m = 1'b0;
    bit         ctrl_m = 1'b0;
    bit         irq_exp = 1'b0;
    bit         abort_req = 1'b0;
    bit         mon_en = 1'b0;

    int         sz;
    int         m_off;
    bit         busy_pre;
    bit         pop_m;
    bit         m_in_win;
    logic [7:0] rv;
    fr_t        fr;

    // Monitor state
    bit   in_frame = 1'b0;
    fr_t  cur;
    int   cur_start;
    int   k;
    int   d1;
    int   bi;
    logic exp_tx;
    rd_t  rexp;

    // Frame-level model: a byte leaves the queue when the line is free, and occupies it for 10*(div+1) clocks.
    always @(posedge clk) begin
        n = n + 1;
        if (rst) begin
            fifo_q.delete();
            busy_until = -1;
            div_m      = 16'(DIV_RESET);
            ovf_m      = 1'b0;
            ctrl_m     = 1'b0;
            irq_exp    = 1'b0;
            abort_req  = 1'b1;
        end else begin
            sz       = fifo_q.size();
            busy_pre = (n <= busy_until);
            m_off    = int'(AD) - int'(BASE);
            m_in_win = (m_off >= 0) && (m_off <= 7);
            irq_exp  = ctrl_m && (sz == 0) && !busy_pre;
            pop_m    = (sz > 0) && (n >= busy_until);
            if (RW && m_in_win) begin
                case (m_off)
                    1:       rv = {4'b0000, ovf_m, (sz == 0), (sz == DEPTH), busy_pre};
                    2:       rv = div_m[7:0];
                    3:       rv = div_m[15:8];
`ifdef MMIO_UART_TX_IRQ_EN
                    4:       rv = {7'b0000000, ctrl_m};
`endif
                    default: rv = 8'h00;
                endcase
                rd_q.push_back('{v: rv, e: n});
                if (m_off == 1) ovf_m = 1'b0;
            end
            if (pop_m) begin
                fr.b = fifo_q.pop_front();
                fr.d = int'(div_m);
                fr.s = n;
                ser_q.push_back(fr);
                busy_until = n + 10 * (int'(div_m) + 1);
            end
            if (!RW && m_in_win) begin
                case (m_off)
                    0: begin
                        if (sz < DEPTH || pop_m) fifo_q.push_back(D_in);
                        else ovf_m = 1'b1;
                    end
                    2: div_m[7:0]  = D_in;
                    3: div_m[15:8] = D_in;
`ifdef MMIO_UART_TX_IRQ_EN
                    4: ctrl_m = D_in[0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // Monitors: serial line, read responses, interrupt.
    always @(negedge clk) begin
        if (abort_req) begin
            abort_req = 1'b0;
            in_frame  = 1'b0;
            ser_q.delete();
        end
        if (mon_en) begin
            if (in_frame) begin
                k  = n - cur_start;
                d1 = cur.d + 1;
                bi = k / d1;
                if (bi == 0) exp_tx = 1'b0;
                else if (bi <= 8) exp_tx = cur.b[bi-1];
                else exp_tx = 1'b1;
                checks++;
                if (tx !== exp_tx) begin
                    errors++;
                    $display("FAIL serial byte %02h clk %0d of frame: tx=%b expected %b", cur.b, k, tx, exp_tx);
                end
                if (k >= 10 * d1 - 1) in_frame = 1'b0;
            end else if (tx !== 1'b1) begin
                checks++;
                if (ser_q.size() == 0) begin
                    errors++;
                    $display("FAIL serial_idle at clk %0d: tx=%b expected 1 (no frame queued)", n, tx);
                end else begin
                    cur       = ser_q.pop_front();
                    cur_start = n;
                    in_frame  = 1'b1;
                    if (cur.s != n || tx !== 1'b0) begin
                        errors++;
                        $display("FAIL frame_start byte %02h: started clk %0d tx=%b, expected clk %0d tx=0", cur.b, n, tx, cur.s);
                    end
                end
            end

            if (rd_q.size() > 0 && rd_q[0].e == n) begin
                rexp = rd_q.pop_front();
                checks++;
                if (hit !== 1'b1 || D_out !== rexp.v) begin
                    errors++;
                    $display("FAIL read_data at clk %0d: hit=%b D_out=%02h, expected hit=1 D_out=%02h", n, hit, D_out, rexp.v);
                end
            end else if (hit !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL read_hit at clk %0d: hit=%b expected 0", n, hit);
            end

`ifdef MMIO_UART_TX_IRQ_EN
            checks++;
            if (irq !== irq_exp) begin
                errors++;
                $display("FAIL irq at clk %0d: irq=%b expected %b", n, irq, irq_exp);
            end
`endif
        end
    end

    task automatic cyc(input logic rw, input logic [15:0] a, input logic [7:0] d);
        RW   = rw;
        AD   = a;
        D_in = d;
        @(negedge clk);
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        cyc(1'b0, BASE + 16'(off), d);
    endtask

    task automatic rd(input int off);
        cyc(1'b1, BASE + 16'(off), 8'h00);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cyc(1'b1, 16'h0000, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b1, 16'h0000, 8'h00);
        rst = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (!(fifo_q.size() == 0 && n >= busy_until && !in_frame) && guard < 5000) begin
            idle(1);
            guard++;
        end
        if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: fifo=%0d busy_until=%0d now=%0d", fifo_q.size(), busy_until, n);
        end
        idle(3);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] a;
        int op;
        int w;

        rst  = 1'b1;
        RW   = 1'b1;
        AD   = 16'h0000;
        D_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_bit("reset_tx", tx, 1'b1);
        check_bit("reset_hit", hit, 1'b0);
        checks++;
        if (D_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %02h expected 00", D_out);
        end
        mon_en = 1'b1;

        // Idle STATUS and all register reads
        rd(1);
        for (int i = 0; i < 8; i++) rd(i);
        idle(3);

        // DIV=3, single byte A5, STATUS mid-frame
        wr(2, 8'h03);
        wr(3, 8'h00);
        wr(0, 8'hA5);
        idle(5);
        rd(1);
        drain();
        rd(1);

        // DIV=0, five contiguous bytes
        wr(2, 8'h00);
        for (int i = 1; i <= 5; i++) wr(0, 8'(i * 8'h11));
        drain();
        rd(1);

        // DIV=15, six bytes: last dropped, overflow reported once
        wr(2, 8'h0F);
        for (int i = 0; i < 6; i++) wr(0, 8'(8'h60 + i));
        rd(1);
        rd(1);
        drain();

        // Reset after three data bits
        wr(0, 8'hC3);
        w = 0;
        while (tx !== 1'b0 && w < 20) begin
            idle(1);
            w++;
        end
        check_bit("frame_began_before_reset", tx, 1'b0);
        idle(64);
        do_reset();
        check_bit("tx_after_reset", tx, 1'b1);
        rd(1);
        idle(200);

        // Randomized traffic
        for (int it = 0; it < 1500; it++) begin
            op = $urandom_range(0, 19);
            if (op <= 7) begin
                wr(0, 8'($urandom));
            end else if (op <= 9) begin
                rd(1);
            end else if (op <= 11) begin
                rd($urandom_range(0, 7));
            end else if (op == 12) begin
                wr(2, 8'($urandom_range(0, 3)));
            end else if (op == 13) begin
                wr($urandom_range(3, 7), 8'h00);
            end else if (op == 14) begin
                a = 16'($urandom);
                if (a >= BASE && a <= BASE + 16'd7) a = 16'h0000;
                cyc(1'($urandom), a, 8'($urandom));
            end else if (op == 15) begin
                cyc(1'($urandom), BASE + 16'd8 + 16'($urandom_range(0, 3)), 8'($urandom));
            end else if (op == 16) begin
                cyc(1'($urandom), BASE - 16'd1 - 16'($urandom_range(0, 3)), 8'($urandom));
            end else if (op <= 18) begin
                idle($urandom_range(0, 30));
            end else if ($urandom_range(0, 9) == 0) begin
                do_reset();
            end else begin
`ifdef MMIO_UART_TX_IRQ_EN
                wr(4, 8'($urandom_range(0, 1)));
`else
                wr(4, 8'($urandom));
`endif
            end
        end
        drain();
        rd(1);
        idle(3);

        // Nothing expected may be left over
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: %0d read responses never appeared", rd_q.size());
        end
        checks++;
        if (ser_q.size() != 0 || in_frame) begin
            errors++;
            $display("FAIL pending_frames: %0d frames never transmitted", ser_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
